kong_anim_ctrl: RTL and testbench
=================================

Name: kong_anim_ctrl

Overview:
Sequencer for the Kong sprite animation. It produces the 4-bit animate_state consumed by the Kong colour/sprite block, and runs the throw cycle NORMAL -> GET -> HOLD -> DROP on per-frame timing. It also issues a barrel-spawn request/acknowledge handshake to the barrel manager at the drop point. It sits between the game FSM (enable/restart) and the display path.

Parameters:
CNT_W, 8, width of the frame counter; every *_FRAMES value is 1..2^CNT_W-1
NORMAL_FRAMES, 60, frame ticks spent in NORMAL before a throw may start
GET_FRAMES, 8, frame ticks in GET
HOLD_FRAMES, 16, frame ticks in HOLD
DROP_FRAMES, 12, minimum frame ticks in DROP

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
frame_tick  in  1  one-cycle pulse per VGA frame
enable  in  1  game running; low freezes the sequence
restart  in  1  synchronous clear to the NORMAL start state
barrel_avail  in  1  barrel manager has a free slot
spawn_ack  in  1  barrel manager accepts the spawn
animate_state  out  4  0=NORMAL, 1=GET, 2=HOLD, 3=DROP; codes 4..15 are never driven
spawn_req  out  1  barrel spawn request, level, held until acked
spawn_count  out  8  barrels thrown since reset/restart

Behaviour:
- All outputs are registered.
- rst (async) and restart (sync, same clk edge) both force:
  - animate_state=0, cnt=0, spawn_req=0, spawn_count=0.
  - restart has priority over all other inputs.
- "adv": frame_tick & enable in the same cycle. Only adv advances cnt and state. With enable=0, state and cnt hold.
- State durations are counted in adv events:
  - When adv occurs with cnt==DUR-1 and the exit condition is met: state changes and cnt clears on that same edge.
  - Otherwise cnt increments on adv, saturating at DUR-1.
- NORMAL: exits to GET when cnt==NORMAL_FRAMES-1, adv, and barrel_avail==1. If barrel_avail==0, it stays NORMAL with cnt saturated; GET is entered on the first adv after barrel_avail rises.
- GET: exits to HOLD after GET_FRAMES adv events, unconditionally.
- HOLD: exits to DROP after HOLD_FRAMES adv events. spawn_req rises on the same edge that animate_state becomes 3.
- Handshake:
  - spawn_req stays high until spawn_ack is sampled high; it clears on the next edge.
  - spawn_count increments on that same edge and wraps 255->0.
  - spawn_ack with spawn_req low is ignored.
  - spawn_ack is accepted regardless of enable or frame_tick.
- DROP: exits to NORMAL on adv with cnt==DROP_FRAMES-1 and spawn_req==0.
  - If the ack arrives on the same edge as the final adv, the exit is taken on the next adv.
  - With a late ack, DROP persists with cnt saturated.
- Full cycle with ack within one tick: 96 adv events at defaults.
- The counter never wraps; the saturation above guarantees this.

Optional Feature:
KONG_RANDOM_IDLE_EN.
- Defined:
  - 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, seed 8'hA5 on rst/restart, steps on every frame_tick (independent of enable).
  - On each entry to NORMAL, the extra delay lfsr[3:0] is latched; the NORMAL duration becomes NORMAL_FRAMES+extra (max +15). The initial NORMAL after reset uses extra=0.
  - CNT_W must hold NORMAL_FRAMES+15.
- Undefined: no LFSR; NORMAL duration is fixed at NORMAL_FRAMES.

Test Plan:
1. Reset, enable=1, barrel_avail=1, spawn_ack pulsed 2 cycles after spawn_req rises, frame_tick every 10 cycles -> animate_state is 0 for ticks 1-59, then 1 from tick 60, 2 from tick 68, 3 from tick 84, 0 from tick 96; spawn_req high 3 cycles; spawn_count=1.
2. barrel_avail=0 for 200 ticks -> animate_state stays 0 and spawn_req=0. Raise barrel_avail -> animate_state=1 on the next tick edge.
3. spawn_ack withheld until tick 120 -> DROP held past tick 96; spawn_req clears one cycle after ack; NORMAL on the next tick; spawn_count=1.
4. enable=0 for 50 ticks at HOLD tick 5 -> animate_state stays 2 and cnt stays 5; after enable=1, DROP comes 11 ticks later. An ack arriving while disabled is still accepted.
5. Async rst asserted mid-DROP with spawn_req=1, off a clock edge -> animate_state=0, spawn_req=0 and spawn_count=0 immediately, before the next clk.
6. restart pulse during GET while spawn_ack=1 -> next edge: state 0, cnt 0, spawn_count 0, no increment. With KONG_RANDOM_IDLE_EN defined, the second NORMAL lasts 60+lfsr[3:0] ticks, matching a reference LFSR model.

Source files
------------

// File: rtl/kong_anim_ctrl.sv
// Kong sprite animation sequencer.
// Runs the throw cycle NORMAL -> GET -> HOLD -> DROP on per-frame timing.
// Raises a level spawn request to the barrel manager on entry to DROP.
// Optional feature macro: KONG_RANDOM_IDLE_EN adds an LFSR-driven extra NORMAL delay (0..15 frames).
// Ports:
//   clk, rst         - clock, asynchronous active-high reset
//   frame_tick       - one-cycle pulse per video frame
//   enable           - game running; low freezes state and frame counter
//   restart          - synchronous clear to NORMAL start, highest priority
//   barrel_avail     - barrel manager has a free slot (gates NORMAL exit)
//   spawn_ack        - barrel manager accepts the pending spawn request
//   animate_state    - 0=NORMAL 1=GET 2=HOLD 3=DROP (registered)
//   spawn_req        - spawn request, held until acknowledged (registered)
//   spawn_count      - barrels thrown since reset/restart, wraps (registered)
module kong_anim_ctrl #(
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned NORMAL_FRAMES = 60,
  parameter int unsigned GET_FRAMES    = 8,
  parameter int unsigned HOLD_FRAMES   = 16,
  parameter int unsigned DROP_FRAMES   = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic       restart,
  input  logic       barrel_avail,
  input  logic       spawn_ack,
  output logic [3:0] animate_state,
  output logic       spawn_req,
  output logic [7:0] spawn_count
);

  localparam logic [CNT_W-1:0] NORMAL_LAST = CNT_W'(NORMAL_FRAMES - 1);
  localparam logic [CNT_W-1:0] GET_LAST    = CNT_W'(GET_FRAMES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_FRAMES - 1);
  localparam logic [CNT_W-1:0] DROP_LAST   = CNT_W'(DROP_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_GET    = 2'd1,
    ST_HOLD   = 2'd2,
    ST_DROP   = 2'd3
  } state_t;

  state_t           state, state_n, exit_to;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             spawn_req_n;
  logic [7:0]       spawn_count_n;
  logic             adv, at_last, exit_ok, take_exit;
  logic [CNT_W-1:0] normal_last;

`ifdef KONG_RANDOM_IDLE_EN
  logic [7:0] lfsr, lfsr_n;
  logic [3:0] extra, extra_n;
  logic       lfsr_fb;

  // x^8+x^6+x^5+x^4+1 feedback, shifted in at the LSB
  assign lfsr_fb     = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign normal_last = NORMAL_LAST + CNT_W'(extra);
`else
  assign normal_last = NORMAL_LAST;
`endif

  assign adv           = frame_tick & enable;
  assign animate_state = {2'b00, state};

  // State register and handshake registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_NORMAL;
      cnt         <= '0;
      spawn_req   <= 1'b0;
      spawn_count <= 8'd0;
`ifdef KONG_RANDOM_IDLE_EN
      lfsr        <= 8'hA5;
      extra       <= 4'd0;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      spawn_req   <= spawn_req_n;
      spawn_count <= spawn_count_n;
`ifdef KONG_RANDOM_IDLE_EN
      lfsr        <= lfsr_n;
      extra       <= extra_n;
`endif
    end
  end

  // Next-state, frame counter and spawn handshake
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    spawn_req_n   = spawn_req;
    spawn_count_n = spawn_count;
    exit_to       = state;
    at_last       = 1'b0;
    exit_ok       = 1'b0;
`ifdef KONG_RANDOM_IDLE_EN
    lfsr_n        = frame_tick ? {lfsr[6:0], lfsr_fb} : lfsr;
    extra_n       = extra;
`endif

    case (state)
      ST_NORMAL: begin
        at_last = (cnt == normal_last);
        exit_ok = barrel_avail;
        exit_to = ST_GET;
      end
      ST_GET: begin
        at_last = (cnt == GET_LAST);
        exit_ok = 1'b1;
        exit_to = ST_HOLD;
      end
      ST_HOLD: begin
        at_last = (cnt == HOLD_LAST);
        exit_ok = 1'b1;
        exit_to = ST_DROP;
      end
      ST_DROP: begin
        // uses the registered request, so an ack on the final tick defers the exit by one tick
        at_last = (cnt == DROP_LAST);
        exit_ok = ~spawn_req;
        exit_to = ST_NORMAL;
      end
      default: begin
        exit_to = ST_NORMAL;
      end
    endcase

    take_exit = adv & at_last & exit_ok;

    // counter saturates at the last value while the exit condition is unmet
    if (take_exit) begin
      state_n = exit_to;
      cnt_n   = '0;
    end else if (adv && !at_last) begin
      cnt_n = cnt + CNT_W'(1);
    end

    if (spawn_req && spawn_ack) begin
      spawn_req_n   = 1'b0;
      spawn_count_n = spawn_count + 8'd1;
    end

    if (take_exit && state == ST_HOLD) begin
      spawn_req_n = 1'b1;
    end

`ifdef KONG_RANDOM_IDLE_EN
    if (take_exit && state == ST_DROP) begin
      extra_n = lfsr[3:0];
    end
`endif

    if (restart) begin
      state_n       = ST_NORMAL;
      cnt_n         = '0;
      spawn_req_n   = 1'b0;
      spawn_count_n = 8'd0;
`ifdef KONG_RANDOM_IDLE_EN
      lfsr_n        = 8'hA5;
      extra_n       = 4'd0;
`endif
    end
  end

endmodule

// File: tb/tb_kong_anim_ctrl.sv
// Self-checking bench for kong_anim_ctrl: table-driven tick runs plus
// hand-written sequences for late ack, enable freeze, async reset and restart.
module tb_kong_anim_ctrl;

  localparam int unsigned NORMAL_FRAMES = 60;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       enable = 1'b0;
  logic       restart = 1'b0;
  logic       barrel_avail = 1'b0;
  logic       spawn_ack = 1'b0;
  logic [3:0] animate_state;
  logic       spawn_req;
  logic [7:0] spawn_count;

  int n_cmp = 0;
  int n_err = 0;
  bit auto_ack = 1'b0;
  int req_age = 0;
  int req_cycles = 0;
  int extra_exp = 0;

  kong_anim_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .frame_tick    (frame_tick),
    .enable        (enable),
    .restart       (restart),
    .barrel_avail  (barrel_avail),
    .spawn_ack     (spawn_ack),
    .animate_state (animate_state),
    .spawn_req     (spawn_req),
    .spawn_count   (spawn_count)
  );

  always #5 clk = ~clk;

`ifdef KONG_RANDOM_IDLE_EN
  logic [7:0] ref_lfsr;
  always @(posedge clk or posedge rst) begin
    if (rst)             ref_lfsr <= 8'hA5;
    else if (restart)    ref_lfsr <= 8'hA5;
    else if (frame_tick) ref_lfsr <= {ref_lfsr[6:0], ref_lfsr[7] ^ ref_lfsr[5] ^ ref_lfsr[4] ^ ref_lfsr[3]};
  end
`endif

  typedef struct {
    string      name;
    int         n_ticks;
    logic       en;
    logic       avail;
    logic [3:0] exp_state;
    logic       exp_req;
    logic [7:0] exp_count;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: land on the falling edge, clear pulses, run the auto-ack responder
  task automatic cyc();
    @(negedge clk);
    frame_tick = 1'b0;
    spawn_ack  = 1'b0;
    restart    = 1'b0;
    if (spawn_req) begin
      req_age++;
      req_cycles++;
    end else begin
      req_age = 0;
    end
    if (auto_ack && req_age == 3) spawn_ack = 1'b1;
  endtask

  // One frame: frame_tick sampled on the next rising edge, then 9 idle clocks
  task automatic tick();
    cyc();
    frame_tick = 1'b1;
    repeat (9) cyc();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_restart();
    cyc();
    restart = 1'b1;
    cyc();
  endtask

  initial begin
    vecs[0]  = '{"normal_t59",   59, 1'b1, 1'b1, 4'd0, 1'b0, 8'd0};
    vecs[1]  = '{"get_t60",       1, 1'b1, 1'b1, 4'd1, 1'b0, 8'd0};
    vecs[2]  = '{"get_t67",       7, 1'b1, 1'b1, 4'd1, 1'b0, 8'd0};
    vecs[3]  = '{"hold_t68",      1, 1'b1, 1'b1, 4'd2, 1'b0, 8'd0};
    vecs[4]  = '{"hold_t83",     15, 1'b1, 1'b1, 4'd2, 1'b0, 8'd0};
    vecs[5]  = '{"drop_t84",      1, 1'b1, 1'b1, 4'd3, 1'b0, 8'd1};
    vecs[6]  = '{"drop_t95",     11, 1'b1, 1'b1, 4'd3, 1'b0, 8'd1};
    vecs[7]  = '{"normal_t96",    1, 1'b1, 1'b1, 4'd0, 1'b0, 8'd1};
    vecs[8]  = '{"noavail_59",   59, 1'b1, 1'b0, 4'd0, 1'b0, 8'd1};
    vecs[9]  = '{"noavail_259", 200, 1'b1, 1'b0, 4'd0, 1'b0, 8'd1};
    vecs[10] = '{"avail_get",     1, 1'b1, 1'b1, 4'd1, 1'b0, 8'd1};
    vecs[11] = '{"avail_hold",    8, 1'b1, 1'b1, 4'd2, 1'b0, 8'd1};
    vecs[12] = '{"avail_drop",   16, 1'b1, 1'b1, 4'd3, 1'b0, 8'd2};
    vecs[13] = '{"avail_normal", 12, 1'b1, 1'b1, 4'd0, 1'b0, 8'd2};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_state", int'(animate_state), 0);
    chk("rst_req",   int'(spawn_req), 0);
    chk("rst_count", int'(spawn_count), 0);
    rst = 1'b0;

    // Full throw cycle, then barrel_avail held low
    auto_ack = 1'b1;
    for (int v = 0; v < 14; v++) begin
      enable       = vecs[v].en;
      barrel_avail = vecs[v].avail;
      ticks(vecs[v].n_ticks);
      chk({vecs[v].name, "_state"}, int'(animate_state), int'(vecs[v].exp_state));
      chk({vecs[v].name, "_req"},   int'(spawn_req),     int'(vecs[v].exp_req));
      chk({vecs[v].name, "_count"}, int'(spawn_count),   int'(vecs[v].exp_count));
    end
    chk("req_high_cycles", req_cycles, 6);

    // Late ack: DROP held saturated, ack on the final tick edge defers exit by one tick
    do_restart();
    auto_ack = 1'b0;
    ticks(84);
    chk("late_drop_state", int'(animate_state), 3);
    chk("late_drop_req",   int'(spawn_req), 1);
    ticks(35);
    chk("late_t119_state", int'(animate_state), 3);
    chk("late_t119_req",   int'(spawn_req), 1);
    chk("late_t119_cnt",   int'(dut.cnt), 11);
    cyc();
    frame_tick = 1'b1;
    spawn_ack  = 1'b1;
    cyc();
    chk("late_ack_state", int'(animate_state), 3);
    chk("late_ack_req",   int'(spawn_req), 0);
    chk("late_ack_count", int'(spawn_count), 1);
    repeat (8) cyc();
    tick();
    chk("late_exit_state", int'(animate_state), 0);
    cyc();
    spawn_ack = 1'b1;
    cyc();
    chk("stray_ack_count", int'(spawn_count), 1);
    chk("stray_ack_req",   int'(spawn_req), 0);

    // Enable freeze in HOLD, ack accepted while disabled
    do_restart();
    auto_ack = 1'b1;
    ticks(68);
    chk("frz_hold_entry", int'(animate_state), 2);
    ticks(5);
    chk("frz_hold_cnt5", int'(dut.cnt), 5);
    enable = 1'b0;
    ticks(50);
    chk("frz_state", int'(animate_state), 2);
    chk("frz_cnt",   int'(dut.cnt), 5);
    enable = 1'b1;
    ticks(10);
    chk("frz_t10_state", int'(animate_state), 2);
    auto_ack = 1'b0;
    tick();
    chk("frz_t11_state", int'(animate_state), 3);
    chk("frz_t11_req",   int'(spawn_req), 1);
    enable = 1'b0;
    cyc();
    spawn_ack = 1'b1;
    cyc();
    chk("dis_ack_req",   int'(spawn_req), 0);
    chk("dis_ack_count", int'(spawn_count), 1);
    ticks(3);
    chk("dis_drop_state", int'(animate_state), 3);
    enable = 1'b1;

    // Async reset mid-DROP with a pending request
    ticks(12);
    chk("pre_rst_normal", int'(animate_state), 0);
    for (int i = 0; i < 200 && spawn_req == 1'b0; i++) tick();
    chk("pre_rst_req",   int'(spawn_req), 1);
    chk("pre_rst_count", int'(spawn_count), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_state", int'(animate_state), 0);
    chk("arst_req",   int'(spawn_req), 0);
    chk("arst_count", int'(spawn_count), 0);
    @(negedge clk);
    rst = 1'b0;

    // Restart during GET with spawn_ack high
    auto_ack = 1'b1;
    ticks(96);
    chk("rs_cycle_count", int'(spawn_count), 1);
    for (int i = 0; i < 100 && animate_state != 4'd1; i++) tick();
    chk("rs_get_state", int'(animate_state), 1);
    ticks(3);
    cyc();
    restart   = 1'b1;
    spawn_ack = 1'b1;
    cyc();
    chk("rs_state", int'(animate_state), 0);
    chk("rs_cnt",   int'(dut.cnt), 0);
    chk("rs_count", int'(spawn_count), 0);
    chk("rs_req",   int'(spawn_req), 0);

    // First NORMAL after restart is the base length; second one adds the latched extra
    ticks(95);
    chk("rs2_drop_state", int'(animate_state), 3);
    cyc();
    frame_tick = 1'b1;
`ifdef KONG_RANDOM_IDLE_EN
    extra_exp = int'(ref_lfsr[3:0]);
`else
    extra_exp = 0;
`endif
    repeat (9) cyc();
    chk("rs2_normal_state", int'(animate_state), 0);
    chk("rs2_count",        int'(spawn_count), 1);
    ticks(int'(NORMAL_FRAMES) + extra_exp - 1);
    chk("rs2_normal_end", int'(animate_state), 0);
    tick();
    chk("rs2_get_state", int'(animate_state), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
